victim_cache_nway: RTL and testbench
====================================

# victim_cache_nway

Parametrised, fully associative victim cache for the data cache. It holds lines evicted from the L1 data cache, each with a valid bit and a dirty bit. On an L1 miss it returns a line on a hit and removes it in the same cycle (swap semantics). When full, it displaces the oldest entry; if that entry is dirty, the block drives it to memory over a ready/valid writeback port. It sits between the data cache controller and the memory-side write path.

## Interface
Parameters:
- LINE_W, 128, cache line width in bits
- TAG_W, 26, full line-address tag width
- ENTRIES, 8, number of entries; power of two, 2..32

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ins_valid  in  1  L1 presents an evicted line
- ins_ready  out  1  insert accepted this cycle
- ins_tag  in  TAG_W  tag of evicted line
- ins_data  in  LINE_W  evicted line data
- ins_dirty  in  1  evicted line is dirty
- lk_valid  in  1  lookup request (L1 miss)
- lk_tag  in  TAG_W  lookup tag
- lk_hit  out  1  combinational hit
- lk_data  out  LINE_W  hit line data; '0 on miss
- lk_dirty  out  1  hit line dirty bit; 0 on miss
- wb_valid  out  1  dirty displaced line pending to memory
- wb_ready  in  1  memory accepts writeback
- wb_tag  out  TAG_W  writeback tag
- wb_data  out  LINE_W  writeback data

## Operation
- Hit: lk_valid and a valid entry with a matching tag. Tags are unique among valid entries, so at most one match. On a hit, the entry's valid bit clears at the next clk edge.
- Insert, on ins_valid & ins_ready at the clk edge:
  - If ins_tag matches a valid entry, update that entry in place: data replaced, dirty = old | ins_dirty. No allocation.
  - Otherwise, write the lowest-index invalid entry.
  - If no entry is invalid, write entry fifo_ptr and increment fifo_ptr modulo ENTRIES.
- Displacement: when a valid dirty entry is overwritten by allocation, its tag and data are loaded into the writeback register. A displaced clean entry is dropped.
- Writeback FSM:
  - IDLE: wb_valid = 0.
  - On a dirty displacement, go to WB_PEND: wb_valid = 1, outputs held stable.
  - WB_PEND to IDLE on wb_valid & wb_ready.
- ins_ready = 0 only when state is WB_PEND, the buffer is full, no entry is freed this cycle, and ins_tag does not match a valid entry. Otherwise ins_ready = 1.
- Simultaneous lookup-hit and insert:
  - The hit entry counts as free for allocation in that cycle.
  - If the allocator picks the hit entry, the insert overwrites it and no writeback is generated for it.
  - If ins_tag == lk_tag on a hit, the in-place update wins and the entry stays valid.
- Lookup during WB_PEND does not search the writeback register.
- fifo_ptr only advances on a full-buffer allocation.

## Timing
- Reset values: all valid = 0, dirty = 0, fifo_ptr = 0, state IDLE, wb_valid = 0, wb_tag = '0, wb_data = '0, lk_hit = 0, ins_ready = 1.
- Data storage is not reset.
- Lookup latency: 0 cycles (combinational). Invalidation is visible on the following cycle.
- Insert latency: 1 edge. A line inserted at edge N hits from cycle N+1.
- wb_valid rises the cycle after the displacing edge. It stays high with stable payload until wb_ready. wb_ready may already be high that cycle.
- Reset asserted mid-writeback drops the pending line. wb_valid goes low immediately.

## Configuration
- VICTIM_CACHE_STATS_EN defined: adds output ports stat_hits, stat_misses and stat_wbs, each 32 bits.
  - Each is a saturating counter, reset to 0.
  - stat_hits increments on lk_valid & lk_hit.
  - stat_misses increments on lk_valid & !lk_hit.
  - stat_wbs increments on a wb handshake.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package victim_cache_pkg holds:
  - the default values of LINE_W, TAG_W and ENTRIES
  - the parametrised entry typedef vc_entry_t {valid, dirty, tag, data}
  - the state enum vc_wb_state_e {VC_IDLE, VC_WB_PEND}
- Sub-module vc_alloc_sel: takes the valid vector, hit one-hot and fifo_ptr; produces the allocation one-hot and a full flag. It uses a lowest-index-invalid priority encoder with FIFO fallback.

## Test plan
- Reset, then lookup tag 0x0 -> lk_hit = 0 (no false hit on zero tags), ins_ready = 1, wb_valid = 0.
- Insert tags 0x10 to 0x17 clean, then lookup 0x13 -> hit with the matching data. The next-cycle lookup of 0x13 -> miss.
- With ENTRIES=8 full of dirty tags 0x20 to 0x27, insert 0x30 -> wb_valid next cycle, wb_tag = 0x20. Hold wb_ready = 0 and insert 0x31 -> ins_ready = 0. Raise wb_ready -> handshake, then 0x31 is accepted and wb_tag = 0x21.
- Insert 0x40 clean, then re-insert 0x40 dirty -> single entry, lk_dirty = 1, no allocation, fifo_ptr unchanged.
- Full buffer with fifo_ptr = 0: lookup-hit on entry 0 (dirty) plus insert 0x50 in the same cycle -> entry 0 holds 0x50 and no writeback. The hit returns the old data.
- Assert rst during WB_PEND -> wb_valid = 0 immediately. All lookups miss after reset.

Source files
------------

// File: rtl/victim_cache_pkg.sv
// Shared definitions for the victim cache: default geometry, the entry
// layout and the writeback FSM state encoding.
package victim_cache_pkg;

    localparam int VC_LINE_W  = 128;
    localparam int VC_TAG_W   = 26;
    localparam int VC_ENTRIES = 8;

    // One victim-cache line at the default geometry.
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [VC_TAG_W-1:0]  tag;
        logic [VC_LINE_W-1:0] data;
    } vc_entry_t;

    typedef enum logic [0:0] {
        VC_IDLE    = 1'b0,
        VC_WB_PEND = 1'b1
    } vc_wb_state_e;

endpackage

// File: rtl/victim_cache_nway_alloc_sel.sv
// Allocation selector: picks the lowest-index free entry (invalid, or being
// removed by a lookup hit this cycle); when none is free, falls back to the
// FIFO pointer and reports the buffer as full.
module vc_alloc_sel #(
    parameter int ENTRIES = 8,
    parameter int PTR_W   = 3
) (
    input  logic [ENTRIES-1:0] valid,
    input  logic [ENTRIES-1:0] hit_oh,
    input  logic [PTR_W-1:0]   fifo_ptr,
    output logic [ENTRIES-1:0] alloc_oh,
    output logic               full
);

    logic [ENTRIES-1:0] free_vec;
    logic               found;

    assign free_vec = ~valid | hit_oh;

    // Priority encode the first free slot, otherwise the oldest entry.
    always_comb begin
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (free_vec[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
        if (!found) begin
            alloc_oh[fifo_ptr] = 1'b1;
        end
        full = !found;
    end

endmodule

// File: rtl/victim_cache_nway.sv
// Fully associative victim cache with swap-on-hit lookup, FIFO displacement
// and a single-entry dirty writeback register.
// Optional: define VICTIM_CACHE_STATS_EN to add hit/miss/writeback counters.
module victim_cache_nway
    import victim_cache_pkg::*;
#(
    parameter int LINE_W  = VC_LINE_W,
    parameter int TAG_W   = VC_TAG_W,
    parameter int ENTRIES = VC_ENTRIES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [TAG_W-1:0]  ins_tag,
    input  logic [LINE_W-1:0] ins_data,
    input  logic              ins_dirty,
    input  logic              lk_valid,
    input  logic [TAG_W-1:0]  lk_tag,
    output logic              lk_hit,
    output logic [LINE_W-1:0] lk_data,
    output logic              lk_dirty,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [LINE_W-1:0] wb_data
`ifdef VICTIM_CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbs
`endif
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    localparam logic [0:0] ST_IDLE    = VC_IDLE;
    localparam logic [0:0] ST_WB_PEND = VC_WB_PEND;

    // Handshakes: a transfer happens on a clk edge where valid and ready are
    // both high; the writeback payload is held stable while wb_valid is high
    // and wb_ready is low.

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] dirty_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [LINE_W-1:0]  data_q [ENTRIES];
    logic [PTR_W-1:0]   fifo_ptr;
    logic [0:0]         state_q;

    logic [ENTRIES-1:0] hit_oh;
    logic [ENTRIES-1:0] ins_match_oh;
    logic [ENTRIES-1:0] alloc_oh;
    logic               full;
    logic               ins_any_match;
    logic               ins_fire;
    logic               alloc_fire;
    logic               displace;

    // Tag search for both the lookup port and the insert port.
    always_comb begin
        hit_oh       = '0;
        ins_match_oh = '0;
        lk_data      = '0;
        lk_dirty     = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lk_valid && valid_q[i] && (tag_q[i] == lk_tag)) begin
                hit_oh[i] = 1'b1;
                lk_data   = lk_data | data_q[i];
                lk_dirty  = lk_dirty | dirty_q[i];
            end
            if (valid_q[i] && (tag_q[i] == ins_tag)) begin
                ins_match_oh[i] = 1'b1;
            end
        end
    end

    assign lk_hit        = |hit_oh;
    assign ins_any_match = |ins_match_oh;

    vc_alloc_sel #(
        .ENTRIES (ENTRIES),
        .PTR_W   (PTR_W)
    ) u_alloc_sel (
        .valid    (valid_q),
        .hit_oh   (hit_oh),
        .fifo_ptr (fifo_ptr),
        .alloc_oh (alloc_oh),
        .full     (full)
    );

    // Only a new allocation into a full buffer can need the writeback
    // register, so stall exactly that case while it is still occupied.
    assign ins_ready  = !((state_q == ST_WB_PEND) && full && !ins_any_match);
    assign ins_fire   = ins_valid && ins_ready;
    assign alloc_fire = ins_fire && !ins_any_match;
    assign displace   = alloc_fire && full && |(alloc_oh & valid_q & dirty_q);
    assign wb_valid   = (state_q == ST_WB_PEND);

    // Valid/dirty bookkeeping: in-place update beats allocation beats
    // swap-out invalidation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (ins_fire && ins_match_oh[i]) begin
                    dirty_q[i] <= dirty_q[i] | ins_dirty;
                end else if (alloc_fire && alloc_oh[i]) begin
                    valid_q[i] <= 1'b1;
                    dirty_q[i] <= ins_dirty;
                end else if (hit_oh[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Line storage; contents are qualified by valid so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (ins_fire && (ins_match_oh[i] || (!ins_any_match && alloc_oh[i]))) begin
                tag_q[i]  <= ins_tag;
                data_q[i] <= ins_data;
            end
        end
    end

    // FIFO pointer moves only when a full buffer forces a displacement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_ptr <= '0;
        end else if (alloc_fire && full) begin
            fifo_ptr <= fifo_ptr + PTR_W'(1);
        end
    end

    // Writeback FSM and payload register; the victim is always fifo_ptr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wb_tag  <= '0;
            wb_data <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (displace) begin
                        state_q <= ST_WB_PEND;
                        wb_tag  <= tag_q[fifo_ptr];
                        wb_data <= data_q[fifo_ptr];
                    end
                end
                default: begin
                    if (wb_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef VICTIM_CACHE_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbs    <= '0;
        end else begin
            if (lk_valid && lk_hit && (stat_hits != '1)) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (lk_valid && !lk_hit && (stat_misses != '1)) begin
                stat_misses <= stat_misses + 32'd1;
            end
            if (wb_valid && wb_ready && (stat_wbs != '1)) begin
                stat_wbs <= stat_wbs + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_victim_cache_nway.sv
// Directed bench for victim_cache_nway at the default geometry.
module tb_victim_cache_nway;

    localparam logic [127:0] SALT = 128'hFFFF_0000_FFFF_0000_5A5A_A5A5_0F0F_F0F0;

    logic         clk;
    logic         rst;
    logic         ins_valid;
    logic         ins_ready;
    logic [25:0]  ins_tag;
    logic [127:0] ins_data;
    logic         ins_dirty;
    logic         lk_valid;
    logic [25:0]  lk_tag;
    logic         lk_hit;
    logic [127:0] lk_data;
    logic         lk_dirty;
    logic         wb_valid;
    logic         wb_ready;
    logic [25:0]  wb_tag;
    logic [127:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;

    victim_cache_nway dut (
        .clk       (clk),
        .rst       (rst),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_tag   (ins_tag),
        .ins_data  (ins_data),
        .ins_dirty (ins_dirty),
        .lk_valid  (lk_valid),
        .lk_tag    (lk_tag),
        .lk_hit    (lk_hit),
        .lk_data   (lk_data),
        .lk_dirty  (lk_dirty),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_tag    (wb_tag),
        .wb_data   (wb_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk_data(input logic [25:0] t);
        return {4{6'b0, t}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
    endtask

    // Insert one line, expecting it to be accepted at the next edge.
    task automatic ins(input logic [25:0] t, input logic d, input logic [127:0] data);
        ins_valid = 1'b1;
        ins_tag   = t;
        ins_data  = data;
        ins_dirty = d;
        #1;
        check_eq("ins_ready", 128'(ins_ready), 128'd1);
        step();
        ins_valid = 1'b0;
    endtask

    task automatic fill(input logic [25:0] base, input logic d);
        for (int k = 0; k < 8; k++) begin
            ins(base + 26'(k), d, mk_data(base + 26'(k)));
        end
    endtask

    // Combinational lookup with no clock edge, so nothing is swapped out.
    task automatic look(input logic [25:0] t, input logic eh, input logic ed, input logic [127:0] edata);
        lk_valid = 1'b1;
        lk_tag   = t;
        #1;
        check_eq("lk_hit", 128'(lk_hit), 128'(eh));
        check_eq("lk_dirty", 128'(lk_dirty), 128'(ed));
        check_eq("lk_data", lk_data, edata);
        lk_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ins_valid = 1'b0; ins_tag = '0; ins_data = '0; ins_dirty = 1'b0;
        lk_valid = 1'b0; lk_tag = '0; wb_ready = 1'b0;

        // Reset state and no false hit on zero tags
        #2;
        lk_valid = 1'b1; lk_tag = 26'h0;
        #1;
        check_eq("rst_lk_hit", 128'(lk_hit), 128'd0);
        check_eq("rst_ins_ready", 128'(ins_ready), 128'd1);
        check_eq("rst_wb_valid", 128'(wb_valid), 128'd0);
        check_eq("rst_wb_tag", 128'(wb_tag), 128'd0);
        check_eq("rst_wb_data", wb_data, 128'd0);
        lk_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        look(26'h0, 1'b0, 1'b0, 128'd0);

        // Clean fill, hit then swap-out
        fill(26'h10, 1'b0);
        check_eq("fill_wb_valid", 128'(wb_valid), 128'd0);
        lk_valid = 1'b1; lk_tag = 26'h13;
        #1;
        check_eq("hit13", 128'(lk_hit), 128'd1);
        check_eq("hit13_data", lk_data, mk_data(26'h13));
        check_eq("hit13_dirty", 128'(lk_dirty), 128'd0);
        step();
        lk_valid = 1'b0;
        look(26'h13, 1'b0, 1'b0, 128'd0);
        look(26'h17, 1'b1, 1'b0, mk_data(26'h17));
        look(26'h10, 1'b1, 1'b0, mk_data(26'h10));

        // Dirty displacement and writeback back-pressure
        do_reset();
        fill(26'h20, 1'b1);
        check_eq("dfill_wb_valid", 128'(wb_valid), 128'd0);
        ins(26'h30, 1'b0, mk_data(26'h30));
        check_eq("wb0_valid", 128'(wb_valid), 128'd1);
        check_eq("wb0_tag", 128'(wb_tag), 128'h20);
        check_eq("wb0_data", wb_data, mk_data(26'h20));
        look(26'h20, 1'b0, 1'b0, 128'd0);
        look(26'h30, 1'b1, 1'b0, mk_data(26'h30));
        ins_valid = 1'b1; ins_tag = 26'h22; ins_data = mk_data(26'h22); ins_dirty = 1'b1;
        #1;
        check_eq("pend_match_ready", 128'(ins_ready), 128'd1);
        ins_tag = 26'h31; ins_data = mk_data(26'h31); ins_dirty = 1'b0;
        #1;
        check_eq("pend_full_ready", 128'(ins_ready), 128'd0);
        step();
        check_eq("hold_wb_valid", 128'(wb_valid), 128'd1);
        check_eq("hold_wb_tag", 128'(wb_tag), 128'h20);
        check_eq("hold_wb_data", wb_data, mk_data(26'h20));
        check_eq("hold_ins_ready", 128'(ins_ready), 128'd0);
        wb_ready = 1'b1;
        #1;
        check_eq("hs_ins_ready", 128'(ins_ready), 128'd0);
        step();
        wb_ready = 1'b0;
        check_eq("hs_wb_valid", 128'(wb_valid), 128'd0);
        check_eq("idle_ins_ready", 128'(ins_ready), 128'd1);
        step();
        ins_valid = 1'b0;
        check_eq("wb1_valid", 128'(wb_valid), 128'd1);
        check_eq("wb1_tag", 128'(wb_tag), 128'h21);
        check_eq("wb1_data", wb_data, mk_data(26'h21));
        look(26'h31, 1'b1, 1'b0, mk_data(26'h31));
        look(26'h21, 1'b0, 1'b0, 128'd0);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check_eq("wb1_done", 128'(wb_valid), 128'd0);

        // In-place update of an existing tag
        do_reset();
        ins(26'h40, 1'b0, mk_data(26'h40));
        ins(26'h40, 1'b1, mk_data(26'h40) ^ SALT);
        look(26'h40, 1'b1, 1'b1, mk_data(26'h40) ^ SALT);
        for (int k = 1; k < 8; k++) begin
            ins(26'h40 + 26'(k), 1'b0, mk_data(26'h40 + 26'(k)));
            check_eq("upd_no_wb", 128'(wb_valid), 128'd0);
        end
        wb_ready = 1'b1;
        ins(26'h48, 1'b0, mk_data(26'h48));
        check_eq("upd_wb_valid", 128'(wb_valid), 128'd1);
        check_eq("upd_wb_tag", 128'(wb_tag), 128'h40);
        check_eq("upd_wb_data", wb_data, mk_data(26'h40) ^ SALT);
        step();
        wb_ready = 1'b0;
        check_eq("upd_wb_done", 128'(wb_valid), 128'd0);

        // Simultaneous hit and insert into a full buffer
        do_reset();
        fill(26'h20, 1'b1);
        lk_valid = 1'b1; lk_tag = 26'h20;
        ins_valid = 1'b1; ins_tag = 26'h50; ins_data = mk_data(26'h50); ins_dirty = 1'b0;
        #1;
        check_eq("swap_hit", 128'(lk_hit), 128'd1);
        check_eq("swap_data", lk_data, mk_data(26'h20));
        check_eq("swap_dirty", 128'(lk_dirty), 128'd1);
        check_eq("swap_ready", 128'(ins_ready), 128'd1);
        step();
        lk_valid = 1'b0; ins_valid = 1'b0;
        check_eq("swap_no_wb", 128'(wb_valid), 128'd0);
        look(26'h50, 1'b1, 1'b0, mk_data(26'h50));
        look(26'h20, 1'b0, 1'b0, 128'd0);
        lk_valid = 1'b1; lk_tag = 26'h22;
        ins_valid = 1'b1; ins_tag = 26'h22; ins_data = mk_data(26'h22) ^ SALT; ins_dirty = 1'b0;
        #1;
        check_eq("same_hit", 128'(lk_hit), 128'd1);
        step();
        lk_valid = 1'b0; ins_valid = 1'b0;
        look(26'h22, 1'b1, 1'b1, mk_data(26'h22) ^ SALT);
        ins(26'h51, 1'b0, mk_data(26'h51));
        check_eq("clean_victim_no_wb", 128'(wb_valid), 128'd0);
        look(26'h50, 1'b0, 1'b0, 128'd0);

        // Reset while a writeback is pending
        do_reset();
        fill(26'h20, 1'b1);
        ins(26'h30, 1'b0, mk_data(26'h30));
        check_eq("pre_rst_wb_valid", 128'(wb_valid), 128'd1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_wb_valid", 128'(wb_valid), 128'd0);
        check_eq("mid_rst_wb_tag", 128'(wb_tag), 128'd0);
        check_eq("mid_rst_ins_ready", 128'(ins_ready), 128'd1);
        rst = 1'b1;
        look(26'h21, 1'b0, 1'b0, 128'd0);
        look(26'h30, 1'b0, 1'b0, 128'd0);
        step();
        check_eq("post_rst_wb_valid", 128'(wb_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
